// File: rtl/axi_dslv_pkg.sv
// Shared definitions for the AXI default slave: response codes, engine
// state encodings and the bit positions inside ERR_FLAGS.
package axi_dslv_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE = 1'b0, W_DATA = 1'b1} w_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

   localparam int ERR_EARLY_LAST   = 0;
   localparam int ERR_MISSING_LAST = 1;
   localparam int ERR_WID_MISMATCH = 2;
   localparam int ERR_FLAG_W       = 3;

endpackage

// File: rtl/axi_dslv_fifo.sv
// Small synchronous FIFO with full/empty flags, used for the AW, AR and B
// queues. DEPTH must be a power of two so the pointers wrap on their own.
module axi_dslv_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push+pop together leaves count alone
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array, needs no reset since occupancy gates every read
   always_ff @(posedge ACLK) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/axi_default_slave_q.sv
// AXI default slave: accepts every transaction, discards write data and
// answers each burst with a fixed response code; reads return a fixed fill
// pattern. Address requests and write responses are queued so several
// transactions may be outstanding.
// Optional protocol checking is enabled with the macro AXI_DSLV_ERRCHK_EN.
module axi_default_slave_q
   import axi_dslv_pkg::*;
#(
   parameter int                    WIDTH_CID  = 4,
   parameter int                    WIDTH_ID   = 4,
   parameter int                    WIDTH_SID  = WIDTH_CID + WIDTH_ID,
   parameter int                    WIDTH_AD   = 32,
   parameter int                    WIDTH_DA   = 32,
   parameter int                    WIDTH_DS   = WIDTH_DA / 8,
   parameter int                    DEPTH_AW   = 4,
   parameter int                    DEPTH_AR   = 4,
   parameter int                    DEPTH_B    = 4,
   parameter logic [1:0]            RESP_CODE  = RESP_DECERR,
   parameter logic [WIDTH_DA-1:0]   RDATA_FILL = '1
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [WIDTH_SID-1:0]  AWID,
   input  logic [WIDTH_AD-1:0]   AWADDR,
   input  logic [7:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [WIDTH_SID-1:0]  WID,
   input  logic [WIDTH_DA-1:0]   WDATA,
   input  logic [WIDTH_DS-1:0]   WSTRB,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [WIDTH_SID-1:0]  BID,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [WIDTH_SID-1:0]  ARID,
   input  logic [WIDTH_AD-1:0]   ARADDR,
   input  logic [7:0]            ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [WIDTH_SID-1:0]  RID,
   output logic [WIDTH_DA-1:0]   RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [ERR_FLAG_W-1:0] ERR_FLAGS
);

   localparam int QW = WIDTH_SID + 8;

   logic          aw_push, aw_pop, aw_full, aw_empty;
   logic [QW-1:0] aw_head;
   logic          ar_push, ar_pop, ar_full, ar_empty;
   logic [QW-1:0] ar_head;
   logic          b_push, b_pop, b_full, b_empty;
   logic [WIDTH_SID-1:0] b_head;

   w_state_e             w_state_q, w_state_d;
   logic [WIDTH_SID-1:0] w_id_q, w_id_d;
   logic [7:0]           w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic                 w_beat, w_end;

   r_state_e             r_state_q, r_state_d;
   logic [WIDTH_SID-1:0] r_id_q, r_id_d;
   logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic                 r_valid_q, r_valid_d, r_last_q, r_last_d;
   logic                 r_beat;

   assign AWREADY = !aw_full && !ARESET;
   assign aw_push = AWVALID && AWREADY;
   assign ARREADY = !ar_full && !ARESET;
   assign ar_push = ARVALID && ARREADY;

   axi_dslv_fifo #(.WIDTH(QW), .DEPTH(DEPTH_AW)) u_aw_fifo (
      .ACLK(ACLK), .ARESET(ARESET), .push(aw_push), .din({AWID, AWLEN}),
      .pop(aw_pop), .dout(aw_head), .full(aw_full), .empty(aw_empty)
   );

   axi_dslv_fifo #(.WIDTH(QW), .DEPTH(DEPTH_AR)) u_ar_fifo (
      .ACLK(ACLK), .ARESET(ARESET), .push(ar_push), .din({ARID, ARLEN}),
      .pop(ar_pop), .dout(ar_head), .full(ar_full), .empty(ar_empty)
   );

   axi_dslv_fifo #(.WIDTH(WIDTH_SID), .DEPTH(DEPTH_B)) u_b_fifo (
      .ACLK(ACLK), .ARESET(ARESET), .push(b_push), .din(w_id_q),
      .pop(b_pop), .dout(b_head), .full(b_full), .empty(b_empty)
   );

   assign WREADY = (w_state_q == W_DATA) && !ARESET;
   assign w_beat = WVALID && WREADY;
   assign w_end  = w_beat && (WLAST || (w_cnt_q == w_len_q));

   // Write engine state register
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
      end
   end

   // Write engine: take a queued AW only when a B slot is free, then sink beats
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      aw_pop    = 1'b0;
      b_push    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (!aw_empty && !b_full) begin
               aw_pop    = 1'b1;
               w_id_d    = aw_head[QW-1:8];
               w_len_d   = aw_head[7:0];
               w_cnt_d   = '0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_end) begin
               b_push    = 1'b1;
               w_cnt_d   = '0;
               w_state_d = W_IDLE;
            end else if (w_beat) begin
               w_cnt_d = w_cnt_q + 8'd1;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign BVALID = !b_empty && !ARESET;
   assign BID    = BVALID ? b_head : '0;
   assign BRESP  = RESP_CODE;
   assign b_pop  = BVALID && BREADY;

   assign RVALID = r_valid_q && !ARESET;
   assign RLAST  = r_last_q && !ARESET;
   assign RID    = RVALID ? r_id_q : '0;
   assign RDATA  = RDATA_FILL;
   assign RRESP  = RESP_CODE;
   assign r_beat = RVALID && RREADY;

   // Read engine state register
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_valid_q <= r_valid_d;
         r_last_q  <= r_last_d;
      end
   end

   // Read engine: launch a queued AR, then stream len+1 beats of fill data
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_valid_d = r_valid_q;
      r_last_d  = r_last_q;
      ar_pop    = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (!ar_empty) begin
               ar_pop    = 1'b1;
               r_id_d    = ar_head[QW-1:8];
               r_len_d   = ar_head[7:0];
               r_cnt_d   = '0;
               r_valid_d = 1'b1;
               r_last_d  = (ar_head[7:0] == 8'd0);
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (r_beat) begin
               if (r_cnt_q == r_len_q) begin
                  r_valid_d = 1'b0;
                  r_last_d  = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d  = r_cnt_q + 8'd1;
                  r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

`ifdef AXI_DSLV_ERRCHK_EN
   logic [ERR_FLAG_W-1:0] err_q;

   // Sticky protocol checks on every accepted write beat
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         err_q <= '0;
      end else if (w_beat) begin
         if (WLAST && (w_cnt_q != w_len_q)) err_q[ERR_EARLY_LAST] <= 1'b1;
         if (!WLAST && (w_cnt_q == w_len_q)) err_q[ERR_MISSING_LAST] <= 1'b1;
         if (WID != w_id_q) err_q[ERR_WID_MISMATCH] <= 1'b1;
      end
   end

   assign ERR_FLAGS = err_q;
`else
   logic unused_wid;
   assign unused_wid = ^WID;
   assign ERR_FLAGS  = '0;
`endif

   logic unused_inputs;
   assign unused_inputs = ^{AWADDR, AWSIZE, AWBURST, WDATA, WSTRB,
                            ARADDR, ARSIZE, ARBURST};

endmodule
